// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
// The optional macro ALU_ARB_STICKY_V_EN adds per-requester sticky overflow bits (sticky_v / sticky_clr).

module alu_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_A,
  input  logic [NREQ*WIDTH-1:0] req_B,
  input  logic [NREQ*4-1:0]     req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_out,
  output logic [3:0]            rsp_flags,
  output logic                  busy
`ifdef ALU_ARB_STICKY_V_EN
  ,
  output logic [NREQ-1:0]       sticky_v,
  input  logic [NREQ-1:0]       sticky_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       sel_q;
  logic [IDW-1:0]   id_q;

  logic             arb_en;
  logic             grant;
  logic [IDW-1:0]   winner;

  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry, alu_ovf;
  logic [3:0]       alu_flags;

  // Arbitration is only live in IDLE, or in RESP once the consumer takes the result.
  // Gating with rst_n keeps req_ready low while reset is held.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first, so no path infers a latch.
    arb_en    = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    grant     = 1'b0;
    winner    = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      int             idx;
      logic [IDW-1:0] idx_l;
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = IDW'(idx);
      if (!grant && req_valid[idx_l]) begin
        grant  = 1'b1;
        winner = idx_l;
      end
    end
    grant = grant && arb_en;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (grant) begin
        a_q   <= req_A[int'(winner)*WIDTH +: WIDTH];
        b_q   <= req_B[int'(winner)*WIDTH +: WIDTH];
        sel_q <= req_sel[int'(winner)*4 +: 4];
        id_q  <= winner;
        rr_q  <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  // The single shared ALU sees only the captured operands, never the live request buses.
  // For subtract, C reports a borrow (A < B unsigned).
  always_comb begin
    alu_wide  = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_out   = a_q & b_q;
    case (sel_q)
      4'h0: begin
        alu_wide  = {1'b0, a_q} + {1'b0, b_q};
        alu_out   = alu_wide[WIDTH-1:0];
        alu_carry = alu_wide[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_out[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h1: begin
        alu_wide  = {1'b0, a_q} - {1'b0, b_q};
        alu_out   = alu_wide[WIDTH-1:0];
        alu_carry = alu_wide[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_out[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h2:    alu_out = a_q & b_q;
      4'h3:    alu_out = a_q | b_q;
      4'h4:    alu_out = a_q ^ b_q;
      4'h5:    alu_out = ~a_q;
      default: alu_out = a_q & b_q;
    endcase
  end

  assign alu_flags = {alu_out[WIDTH-1], ~|alu_out, alu_carry, alu_ovf};

  // rsp_valid stays up across a handshake that also grants the next op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= '0;
      rsp_flags <= '0;
    end else if (state_q == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_q;
      rsp_out   <= alu_out;
      rsp_flags <= alu_flags;
    end else if ((state_q == RESP) && rsp_ready && !grant) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef ALU_ARB_STICKY_V_EN
  logic [NREQ-1:0] sticky_set;

  always_comb begin
    sticky_set = '0;
    if ((state_q == EXEC) && alu_flags[0]) sticky_set[id_q] = 1'b1;
  end

  // Set wins over clear for the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_v <= '0;
    else        sticky_v <= (sticky_v & ~sticky_clr) | sticky_set;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model.
// Build with ALU_ARB_STICKY_V_EN defined to also exercise the sticky overflow bits.

module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_A;
  logic [NREQ*WIDTH-1:0] req_B;
  logic [NREQ*4-1:0]     req_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_out;
  logic [3:0]            rsp_flags;
  logic                  busy;
`ifdef ALU_ARB_STICKY_V_EN
  logic [NREQ-1:0]       sticky_v;
  logic [NREQ-1:0]       sticky_clr;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
    .busy      (busy)
`ifdef ALU_ARB_STICKY_V_EN
    ,
    .sticky_v  (sticky_v),
    .sticky_clr(sticky_clr)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] out;
    logic [3:0]  flags;
  } rsp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Transaction-level model: protocol phase, rr pointer, results in flight.
  int   m_phase;   // 0 idle, 1 executing, 2 response presented
  int   m_rr;
  bit   m_hold;    // previous response still shown while the next op executes
  rsp_t m_rsp;
  rsp_t exp_q[$];
  int   grant_log[$];
  int   grant_cyc[$];
  logic [NREQ-1:0] m_sticky;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    rsp_t   r;
    longint ua, ub, sa, sb, u, s;
    bit     c, v;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    r.id = 0;
    case (sel)
      4'h0: begin
        u = ua + ub; s = sa + sb;
        r.out = u[31:0];
        c = (u > 64'sd4294967295);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1: begin
        u = ua - ub; s = sa - sb;
        r.out = u[31:0];
        c = (ua < ub);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3:    r.out = a | b;
      4'h4:    r.out = a ^ b;
      4'h5:    r.out = ~a;
      default: r.out = a & b;
    endcase
    r.flags = {r.out[31], (r.out == 32'd0), c, v};
    return r;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_rr     = 0;
    m_hold   = 1'b0;
    m_sticky = '0;
    exp_q.delete();
  endtask

  // Called at the falling edge: compare outputs, then advance the model across the next rising edge.
  task automatic model_step();
    logic [NREQ-1:0] exp_ready;
    int   win;
    bit   arb_en, exp_rv;
    rsp_t r;
`ifdef ALU_ARB_STICKY_V_EN
    logic [NREQ-1:0] ns;
`endif
    arb_en    = (m_phase == 0) || ((m_phase == 2) && rsp_ready);
    win       = -1;
    exp_ready = '0;
    if (arb_en) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, m_phase != 0);
    exp_rv = (m_phase == 2) || ((m_phase == 1) && m_hold);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      chk("rsp_out", rsp_out, m_rsp.out);
      chk("rsp_flags", rsp_flags, m_rsp.flags);
      chk("rsp_id", rsp_id, m_rsp.id);
    end
`ifdef ALU_ARB_STICKY_V_EN
    chk("sticky_v", sticky_v, m_sticky);
    ns = m_sticky & ~sticky_clr;
    if (m_phase == 1 && exp_q.size() > 0 && exp_q[0].flags[0]) ns[exp_q[0].id] = 1'b1;
    m_sticky = ns;
`endif
    if (win >= 0) begin
      r = ref_alu(req_A[win*32 +: 32], req_B[win*32 +: 32], req_sel[win*4 +: 4]);
      r.id = win;
      exp_q.push_back(r);
      grant_log.push_back(win);
      grant_cyc.push_back(cyc);
      m_rr    = (win + 1) % NREQ;
      m_hold  = (m_phase == 2);
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_rsp   = exp_q.pop_front();
      m_phase = 2;
    end else if (m_phase == 2 && rsp_ready) begin
      m_phase = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    req_A[i*32 +: 32] = a;
    req_B[i*32 +: 32] = b;
    req_sel[i*4 +: 4] = s;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_out"}, rsp_out, 0);
    chk({tag, "_rsp_flags"}, rsp_flags, 0);
`ifdef ALU_ARB_STICKY_V_EN
    chk({tag, "_sticky"}, sticky_v, 0);
`endif
  endtask

  // One directed op from requester i, checked against constants two edges after its grant.
  task automatic directed_op(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] s, input logic [31:0] exp_out, input logic [3:0] exp_flags);
    set_req(i, a, b, s);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    rsp_ready    = 1'b1;
    cycle();
    req_valid = '0;
    chk({tag, "_lat"}, rsp_valid, 0);
    cycle();
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_out"}, rsp_out, exp_out);
    chk({tag, "_flags"}, rsp_flags, exp_flags);
    chk({tag, "_id"}, rsp_id, i);
    cycle();
  endtask

  initial begin
    logic [39:0] snap;
    int          guard;
    int          exp_order[5] = '{0, 1, 2, 3, 0};

    req_valid = '0;
    req_A     = '0;
    req_B     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_STICKY_V_EN
    sticky_clr = '0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Single ops: plain add, signed overflow, zero result
    directed_op("t2", 0, 32'd5, 32'd3, 4'b0000, 32'd8, 4'b0000);
    directed_op("t3", 2, 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 4'b1001);
`ifdef ALU_ARB_STICKY_V_EN
    chk("t3_sticky", sticky_v[2], 1);
`endif
    directed_op("t4", 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0100, 32'd0, 4'b0100);

    // Reset in the middle of an op: nothing may come out afterwards
    set_req(3, 32'd1, 32'd1, 4'b0000);
    req_valid = 4'b1000;
    cycle();
    chk("t1_busy_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t1");
    @(posedge clk);
    #1;
    check_reset_outputs("t1_hold");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    repeat (4) cycle();
    chk("t1_no_rsp", rsp_valid, 0);

    // Round robin with all requesters pending
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
    grant_log.delete();
    grant_cyc.delete();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    guard = 0;
    while (grant_log.size() < 5 && guard < 30) begin
      cycle();
      guard++;
    end
    chk("t5_grants", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t5_order", grant_log[i], exp_order[i]);
    for (int i = 1; i < grant_cyc.size(); i++) chk("t5_gap", grant_cyc[i] - grant_cyc[i-1], 2);

    // Backpressure: response held, requester 3 waits
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    cycle();
    snap = {rsp_id, 2'b00, rsp_flags, rsp_out};
    repeat (5) cycle();
    chk("t6_stable", {rsp_id, 2'b00, rsp_flags, rsp_out}, snap);
    chk("t6_id", rsp_id, 0);
    chk("t6_valid", rsp_valid, 1);
    grant_log.delete();
    rsp_ready = 1'b1;
    cycle();
    chk("t6_grant", (grant_log.size() == 1) ? grant_log[0] : -1, 3);
    req_valid = '0;
    repeat (3) cycle();

    // Random traffic
    repeat (400) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARB_STICKY_V_EN
      sticky_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
`endif
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
`ifdef ALU_ARB_STICKY_V_EN
    sticky_clr = '0;
`endif
    repeat (4) cycle();
    chk("drain_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
